irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Memory-mapped interrupt controller between the interrupt sources (TC0 IRQ, TC1 IRQ, external interrupt, spares) and the CP0 HWInt input of the CPU.
- Latches and masks requests, selects one by fixed priority, and presents it to CP0 as a single one-hot HWInt bit.
- Holds that bit until CP0 acknowledges, then keeps the source in service until software writes end-of-interrupt (EOI).
- Attached to the Bridge as a third device, beside TC0 and TC1, with the same Addr/WE/Din/Dout port style.

Parameters:
- NSRC, 6, number of interrupt sources; matches the HWInt width.
- IDXW, 3, width of the in-service index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- irq_src  in  NSRC  raw requests; bit0=TC0, bit1=TC1, bit2=external, bits 5:3 spare; all in the clk domain
- Addr  in  3  word address [4:2] within the device window
- WE  in  1  register write strobe from the Bridge
- Din  in  32  write data
- Dout  out  32  read data, combinational from Addr
- int_ack  in  1  one-cycle pulse from CP0 when it takes the interrupt
- HWInt  out  NSRC  to CP0 HWInt; at most one bit set
- busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Register map (word offset):
  - 0 MASK: RW, bits [5:0], 1 = enabled.
  - 1 MODE: RW, bits [5:0], 1 = edge-triggered, 0 = level-triggered.
  - 2 PEND: read returns the pending vector; a write clears, write-1-to-clear, the edge-mode pending bits only.
  - 3 SVC: read returns {busy, 28'b0, svc_idx[2:0]}; any write is an EOI.
  - 4 MISS: see Optional Feature.
  - 5-7: read 0, writes ignored.
  - Unused register bits read 0.
- Reset (synchronous) clears MASK, MODE, edge pending, src_q, svc_idx and MISS, and puts the FSM in IDLE. Result: HWInt=0, busy=0.
- src_q is a one-cycle registered copy of irq_src.
- Edge-mode pending bit i:
  - set at the clock edge where irq_src[i]=1 and src_q[i]=0;
  - cleared by a PEND W1C write or by an EOI whose svc_idx=i;
  - if a set and a clear happen in the same cycle, the set wins.
- Level-mode pending bit i = src_q[i]. It is not cleared by EOI.
- cand = pending & MASK. The winner is the lowest set index (bit0 highest priority).
- FSM:
  - IDLE: if cand≠0, latch the winner into svc_idx and go to ASSERT. Otherwise stay.
  - ASSERT: HWInt = one-hot(svc_idx).
    - If int_ack=1, go to INSERVICE.
    - Else if cand[svc_idx]=0 (source masked or level dropped), go to IDLE (cancel) with no EOI needed.
    - int_ack takes priority over cancel.
  - INSERVICE: HWInt=0. An EOI write clears pending[svc_idx] if that source is edge-mode, then go to IDLE.
- An EOI write in IDLE or ASSERT is ignored.
- The winner is not re-evaluated in ASSERT or INSERVICE. A higher-priority request waits for IDLE; there is no nesting.
- Latency: a rising edge on irq_src before clock edge k sets pending at k, enters ASSERT at k+1, and HWInt is visible after k+1.
- Back-to-back: EOI at edge e with another candidate pending gives ASSERT at e+1.
- An int_ack pulse outside ASSERT is ignored.
- Register writes take effect at the clock edge. Reads reflect the pre-edge state.

Optional Feature:
- Macro IRQ_SEQUENCER_MISS_EN.
- When defined:
  - MISS (offset 4) holds six 4-bit saturating counters, at bits [4i+3:4i].
  - Counter i increments when an edge is detected on a source whose pending bit is already 1. It saturates at 15.
  - Any write to MISS clears all counters.
  - Reset clears all counters.
- When undefined: no counters are synthesized, offset 4 reads 0, and writes to it are ignored.

Test Plan:
- Reset, then MASK=0x3F, MODE=0x01, pulse irq_src[0] for 1 cycle at edge k. Required: PEND=0x01 after k, HWInt=6'b000001 after k+1, busy=1.
- From ASSERT, pulse int_ack. Required: HWInt=0, SVC reads 0x80000000. Then write SVC. Required: PEND=0x00, busy=0, SVC=0.
- Edge on sources 1 and 0 in the same cycle with both enabled. Required: svc_idx=0 first; after ack and EOI, HWInt=6'b000010 one cycle after the EOI edge.
- Level source 2 (MODE=0) held high, MASK bit2 cleared while in ASSERT. Required: FSM returns to IDLE, HWInt=0, no ack needed. Re-enable MASK. Required: HWInt=6'b000100 again.
- Edge on source 1 in the same cycle as a PEND write of 0x02. Required: PEND bit1 remains 1.
- With IRQ_SEQUENCER_MISS_EN, 20 edges on source 1 while it stays pending with no EOI. Required: MISS[7:4]=15. Write MISS. Required: reads 0. Without the macro, MISS reads 0.

Source files
------------

// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer feeding CP0 HWInt, Bridge-attached.
// Optional miss counters at offset 4 under IRQ_SEQUENCER_MISS_EN.
module irq_sequencer #(
  parameter int NSRC = 6,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [2:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic            int_ack,
  output logic [NSRC-1:0] HWInt,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    INSERVICE
  } state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] mask, mode, epend, src_q;
  logic [NSRC-1:0] edge_det, pend, cand, svc_oh, clr;
  logic [IDXW-1:0] svc_idx, idx_nxt, win;
  logic [31:0]     miss_word;
  logic            wr_mask, wr_mode, wr_pend, eoi, eoi_clr;

  assign wr_mask  = WE && (Addr == 3'd0);
  assign wr_mode  = WE && (Addr == 3'd1);
  assign wr_pend  = WE && (Addr == 3'd2);
  assign eoi      = WE && (Addr == 3'd3);

  assign edge_det = irq_src & ~src_q;
  assign pend     = (epend & mode) | (src_q & ~mode);
  assign cand     = pend & mask;
  assign svc_oh   = NSRC'(1) << svc_idx;
  assign eoi_clr  = eoi && (state == INSERVICE);

  assign clr = (wr_pend ? Din[NSRC-1:0] : '0)
             | (eoi_clr ? svc_oh : '0);

  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (cand[i]) win = IDXW'(i);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = svc_idx;
    unique case (state)
      IDLE: begin
        if (|cand) begin
          idx_nxt   = win;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        // ack beats cancel when both happen in one cycle
        if (int_ack)             state_nxt = INSERVICE;
        else if (!cand[svc_idx]) state_nxt = IDLE;
      end
      INSERVICE: begin
        if (eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      svc_idx <= '0;
      mask    <= '0;
      mode    <= '0;
      epend   <= '0;
      src_q   <= '0;
    end else begin
      state   <= state_nxt;
      svc_idx <= idx_nxt;
      src_q   <= irq_src;
      // set wins over a same-cycle clear
      epend   <= (epend & ~clr) | (edge_det & mode);
      if (wr_mask) mask <= Din[NSRC-1:0];
      if (wr_mode) mode <= Din[NSRC-1:0];
    end
  end

`ifdef IRQ_SEQUENCER_MISS_EN
  logic [3:0] miss_cnt [NSRC];
  logic       wr_miss;

  assign wr_miss = WE && (Addr == 3'd4);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (reset || wr_miss)
        miss_cnt[i] <= '0;
      else if (edge_det[i] && pend[i] && miss_cnt[i] != 4'hF)
        miss_cnt[i] <= miss_cnt[i] + 4'd1;
    end
  end

  always_comb begin
    miss_word = '0;
    for (int i = 0; i < NSRC; i++)
      miss_word[4*i +: 4] = miss_cnt[i];
  end
`else
  assign miss_word = '0;
`endif

  assign busy  = (state != IDLE);
  assign HWInt = (state == ASSERT) ? svc_oh : '0;

  always_comb begin
    Dout = '0;
    case (Addr)
      3'd0:    Dout = 32'(mask);
      3'd1:    Dout = 32'(mode);
      3'd2:    Dout = 32'(pend);
      3'd3:    Dout = {busy, {(31-IDXW){1'b0}}, svc_idx};
      3'd4:    Dout = miss_word;
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed scoreboard bench for irq_sequencer.
// Expected values queued at stimulus, popped at each check.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_src;
  logic [2:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        int_ack;
  logic [5:0]  HWInt;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] rd;

  irq_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .int_ack (int_ack),
    .HWInt   (HWInt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic rdreg(input logic [2:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; Addr = '0;
    WE = 1'b0; Din = '0; int_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;

    expect_v(32'h0); check("rst_hwint", 32'(HWInt));
    expect_v(32'h0); check("rst_busy", 32'(busy));
    expect_v(32'h0); rdreg(3'd0, rd); check("rst_mask", rd);
    expect_v(32'h0); rdreg(3'd3, rd); check("rst_svc", rd);

    // single edge source 0
    wr(3'd0, 32'h3F);
    wr(3'd1, 32'h01);
    irq_src = 6'b000001;
    tick();
    irq_src = '0;
    expect_v(32'h01); rdreg(3'd2, rd); check("pend_k", rd);
    expect_v(32'h0);  check("hwint_k", 32'(HWInt));
    tick();
    expect_v(32'h01); check("hwint_k1", 32'(HWInt));
    expect_v(32'h1);  check("busy_k1", 32'(busy));

    int_ack = 1'b1; tick(); int_ack = 1'b0;
    expect_v(32'h0);        check("hwint_ack", 32'(HWInt));
    expect_v(32'h80000000); rdreg(3'd3, rd); check("svc_insvc", rd);
    wr(3'd3, 32'h0);
    expect_v(32'h0); rdreg(3'd2, rd); check("pend_eoi", rd);
    expect_v(32'h0); check("busy_eoi", 32'(busy));
    expect_v(32'h0); rdreg(3'd3, rd); check("svc_eoi", rd);

    // simultaneous edges on 1 and 0
    wr(3'd1, 32'h03);
    irq_src = 6'b000011;
    tick();
    irq_src = '0;
    tick();
    expect_v(32'h01); check("prio_first", 32'(HWInt));
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    wr(3'd3, 32'h0);
    expect_v(32'h0);  check("b2b_eoi_edge", 32'(HWInt));
    tick();
    expect_v(32'h02); check("b2b_next", 32'(HWInt));
    expect_v(32'h80000001); int_ack = 1'b1; tick(); int_ack = 1'b0;
    rdreg(3'd3, rd); check("svc_idx1", rd);
    wr(3'd3, 32'h0);
    expect_v(32'h0); rdreg(3'd2, rd); check("pend_clean", rd);

    // level source 2 cancel by mask
    irq_src = 6'b000100;
    tick(); tick();
    expect_v(32'h04); check("lvl_assert", 32'(HWInt));
    wr(3'd0, 32'h3B);
    tick();
    expect_v(32'h0); check("lvl_cancel_hw", 32'(HWInt));
    expect_v(32'h0); check("lvl_cancel_busy", 32'(busy));
    expect_v(32'h04); rdreg(3'd2, rd); check("lvl_pend", rd);
    wr(3'd0, 32'h3F);
    tick();
    expect_v(32'h04); check("lvl_reassert", 32'(HWInt));
    irq_src = '0;
    tick(); tick();
    expect_v(32'h0); check("lvl_drop", 32'(busy));

    // set beats W1C clear in the same cycle
    wr(3'd0, 32'h00);
    irq_src = 6'b000010;
    wr(3'd2, 32'h02);
    irq_src = '0;
    expect_v(32'h02); rdreg(3'd2, rd); check("set_wins", rd);
    expect_v(32'h0);  check("masked_idle", 32'(busy));

    // repeated edges on already-pending source 1
    for (int i = 0; i < 20; i++) begin
      irq_src = 6'b000010; tick();
      irq_src = '0;        tick();
    end
`ifdef IRQ_SEQUENCER_MISS_EN
    expect_v(32'h000000F0);
`else
    expect_v(32'h0);
`endif
    rdreg(3'd4, rd); check("miss_sat", rd);
    wr(3'd4, 32'hFFFFFFFF);
    expect_v(32'h0); rdreg(3'd4, rd); check("miss_clr", rd);
    wr(3'd2, 32'h02);
    expect_v(32'h0); rdreg(3'd2, rd); check("w1c", rd);
    wr(3'd5, 32'hFFFFFFFF);
    expect_v(32'h0); rdreg(3'd5, rd); check("unused5", rd);
    expect_v(32'h0); rdreg(3'd0, rd); check("mask_keep", rd);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
